// File: rtl/dtcm_lsu_pkg.sv
// Shared types for the DTCM load/store unit: access size encoding, controller
// states and the alignment rule.
package dtcm_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    LD_WAIT,
    ST_MERGE,
    RESP
  } state_e;

  // A request is rejected when its size is reserved or its address is not
  // naturally aligned to that size.
  function automatic logic access_err(input size_e size, input logic [1:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dtcm_byte_lane.sv
// Little-endian lane logic: extracts and extends a load lane from a TCM word,
// and merges sub-word store data into a TCM word.
module dtcm_byte_lane
  import dtcm_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  size_e                 size,
  input  logic                  sign_ext,
  input  logic [1:0]            off,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merge_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{off, 3'b000} +: 8];
  assign half_lane = rdata[{off[1], 4'b0000} +: 16];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    load_data = rdata;
    case (size)
      SZ_B: load_data = {{(DATA_WIDTH-8){sign_ext & byte_lane[7]}}, byte_lane};
      SZ_H: load_data = {{(DATA_WIDTH-16){sign_ext & half_lane[15]}}, half_lane};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merge_data = rdata;
    case (size)
      SZ_B: merge_data[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_H: merge_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/dtcm_lsu_ctrl.sv
// Load/store controller for a 1-cycle-latency data TCM: one access in flight,
// read-modify-write for sub-word stores, single-cycle response pulse.
module dtcm_lsu_ctrl
  import dtcm_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  tcm_we,
  output logic [ADDR_WIDTH-1:0] tcm_addr,
  output logic [DATA_WIDTH-1:0] tcm_wdata,
  input  logic [DATA_WIDTH-1:0] tcm_rdata
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            off_q;
  size_e                 size_q;
  logic                  signed_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  size_e                 req_sz;
  logic                  accept;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

  assign req_sz  = size_e'(req_size);
  assign accept  = req_valid && req_ready;
  assign req_err = access_err(req_sz, req_addr[1:0]);

  // Lane logic always works from the captured request; both LD_WAIT and
  // ST_MERGE consume the TCM word read in the accept cycle.
  dtcm_byte_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .size       (size_q),
    .sign_ext   (signed_q),
    .off        (off_q),
    .rdata      (tcm_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Ready and the merge write are qualified by rst_n so nothing is accepted or
  // written while reset is held, even though IDLE is entered asynchronously.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    tcm_we    = 1'b0;
    tcm_addr  = addr_q;
    tcm_wdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = rst_n;
        tcm_addr  = req_addr[ADDR_WIDTH+1:2];
        if (accept) begin
          if (req_err) begin
            state_d = RESP;
          end else if (!req_we) begin
            state_d = LD_WAIT;
          end else if (req_sz == SZ_W) begin
            tcm_we    = 1'b1;
            tcm_wdata = req_wdata;
            state_d   = RESP;
          end else begin
            state_d = ST_MERGE;
          end
        end
      end
      LD_WAIT: state_d = RESP;
      ST_MERGE: begin
        tcm_we    = rst_n;
        tcm_wdata = merge_data;
        state_d   = RESP;
      end
      default: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      off_q    <= '0;
      size_q   <= SZ_B;
      signed_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr[ADDR_WIDTH+1:2];
        off_q    <= req_addr[1:0];
        size_q   <= req_sz;
        signed_q <= req_signed;
        wdata_q  <= req_wdata;
        rdata_q  <= '0;
        err_q    <= req_err;
      end else if (state_q == LD_WAIT) begin
        rdata_q <= load_data;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dtcm_lsu_ctrl.sv
// Self-checking bench for dtcm_lsu_ctrl: directed corner cases plus random
// accesses against a word-array reference model and a 1-cycle TCM model.
module tb_dtcm_lsu_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          tcm_we;
  logic [AW-1:0] tcm_addr;
  logic [DW-1:0] tcm_wdata;
  logic [DW-1:0] tcm_rdata;

  always #5 clk = ~clk;

  dtcm_lsu_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .tcm_we     (tcm_we),
    .tcm_addr   (tcm_addr),
    .tcm_wdata  (tcm_wdata),
    .tcm_rdata  (tcm_rdata)
  );

  // Synchronous word memory with a bench-side preload port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (tcm_we) mem[tcm_addr] <= tcm_wdata;
    tcm_rdata <= mem[tcm_addr];
  end

  int unsigned we_count = 0;
  int unsigned acc_count = 0;
  always @(posedge clk) begin
    if (tcm_we) we_count <= we_count + 1;
    if (req_valid && req_ready) acc_count <= acc_count + 1;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned n_ops = 0;
  logic [31:0] ref_mem [0:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] size, input logic [11:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  // Lane value by shift and modulo; sign extension by two's-complement wrap.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                           input bit sgn, input logic [1:0] off);
    logic [31:0] v, lim;
    if (size == 2'd2) return word;
    lim = (size == 2'd0) ? 32'h100 : 32'h10000;
    v = (word >> (8 * off)) % lim;
    if (sgn && v >= lim / 2) v = v - lim;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] off, input logic [31:0] wdata);
    logic [31:0] lim, mask;
    if (size == 2'd2) return wdata;
    lim  = (size == 2'd0) ? 32'h100 : 32'h10000;
    mask = (lim - 1) << (8 * off);
    return (word & ~mask) | ((wdata % lim) << (8 * off));
  endfunction

  task automatic preload(input int widx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = AW'(widx); pre_data = val;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[widx] = val;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the
  // IDLE cycle following the response. Busy cycles carry random requests that
  // must be ignored.
  task automatic do_op(input bit we, input logic [1:0] size, input bit sgn,
                       input logic [11:0] addr, input logic [31:0] wdata);
    bit          err, merge_st, wr;
    int          lat, n, widx;
    logic [31:0] old_word, new_word, exp_rd;
    int unsigned we0, acc0;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    #1;
    err      = ref_err(size, addr);
    wr       = we && !err;
    merge_st = wr && size != 2'd2;
    widx     = int'(addr >> 2);
    old_word = ref_mem[widx];
    new_word = wr ? ref_store(old_word, size, addr[1:0], wdata) : old_word;
    exp_rd   = (!err && !we) ? ref_load(old_word, size, sgn, addr[1:0]) : 32'h0;
    lat      = (err || (we && size == 2'd2)) ? 1 : 2;
    check("ready_idle", 32'(req_ready), 32'd1);
    check("tcm_addr_idle", 32'(tcm_addr), 32'(addr >> 2));
    check("we_at_accept", 32'(tcm_we), 32'(wr && size == 2'd2));
    if (wr && size == 2'd2) check("wdata_at_accept", tcm_wdata, wdata);
    we0 = we_count; acc0 = acc_count;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    while (1) begin
      req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
      req_signed = 1'($urandom); req_addr = 12'($urandom_range(0, 63)); req_wdata = $urandom;
      #1;
      check("tcm_we_busy", 32'(tcm_we), 32'(n == 1 && merge_st));
      if (n == 1 && merge_st) check("merge_wdata", tcm_wdata, new_word);
      check("ready_busy", 32'(req_ready), 32'd0);
      if (rsp_valid || n == 5) break;
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("rsp_err", 32'(rsp_err), 32'(err));
    check("rsp_rdata", rsp_rdata, exp_rd);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check("write_count", we_count - we0, 32'(wr));
    check("accept_count", acc_count - acc0, 32'd1);
    ref_mem[widx] = new_word;
    n_ops++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned we0;
    // Reset held with a store request presented: nothing may be accepted.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 12'h010; req_wdata = 32'h12345678;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b0;
      preload(i, $urandom);
      req_valid = 1'b1;
    end
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_tcm_we", 32'(tcm_we), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_no_accept", acc_count, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;

    // Accept in the first cycle out of reset; word store then word load.
    do_op(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF);
    do_op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);

    // Byte store over a known word.
    preload(4, 32'h11223344);
    do_op(1'b1, 2'd0, 1'b0, 12'h013, 32'h0000005A);
    check("mem_byte_merge", mem[4], 32'h5A223344);
    do_op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);

    // Signed and unsigned byte load of the top lane.
    preload(4, 32'h80000000);
    do_op(1'b0, 2'd0, 1'b1, 12'h013, 32'h0);
    do_op(1'b0, 2'd0, 1'b0, 12'h013, 32'h0);
    do_op(1'b0, 2'd1, 1'b1, 12'h012, 32'h0);

    // Error cases leave memory untouched.
    preload(4, 32'hA5A5C3C3);
    do_op(1'b1, 2'd1, 1'b0, 12'h011, 32'hFFFFFFFF);
    do_op(1'b0, 2'd2, 1'b0, 12'h002, 32'h0);
    do_op(1'b1, 2'd3, 1'b0, 12'h010, 32'hFFFFFFFF);
    check("mem_after_err", mem[4], 32'hA5A5C3C3);
    do_op(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);

    // Reset pulsed during the merge cycle of a byte store.
    preload(5, 32'hCAFEF00D);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 12'h015; req_wdata = 32'h000000AB;
    #1;
    we0 = we_count;
    @(posedge clk);
    n_ops++;
    @(negedge clk);
    req_size = 2'd2;
    #1;
    check("merge_we_before_rst", 32'(tcm_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_tcm_we", 32'(tcm_we), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("abort_hold_valid", 32'(rsp_valid), 32'd0);
      check("abort_hold_we", 32'(tcm_we), 32'd0);
    end
    check("abort_no_write", we_count - we0, 32'd0);
    check("abort_mem", mem[5], 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    do_op(1'b0, 2'd2, 1'b0, 12'h014, 32'h0);

    // Random mixed traffic over the preloaded window.
    for (int i = 0; i < 160; i++) begin
      do_op(1'($urandom), 2'($urandom), 1'($urandom), 12'($urandom_range(0, 63)), $urandom);
    end

    #1;
    check("total_accepts", acc_count, n_ops);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
